// File: rtl/ir_beacon_pkg.sv
// Shared definitions for the IR beacon link: FSM states, unit counts per
// frame element, and helpers that turn clock and timing parameters into cycles.
package ir_beacon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_MARK,
    HDR_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GUARD
  } beaconState_t;

  // Length of each frame element, in base timing units
  localparam int HDR_MARK_U   = 4;
  localparam int HDR_SPACE_U  = 2;
  localparam int ZERO_SPACE_U = 1;
  localparam int ONE_SPACE_U  = 2;
  localparam int MARK_U       = 1;

  // Carrier half-period in clock cycles
  function automatic int calcCarDiv(input int clkHz, input int carrierHz);
    return clkHz / (2 * carrierHz);
  endfunction

  // Base timing unit in clock cycles
  function automatic int calcUnitCyc(input int clkHz, input int unitUs);
    return (clkHz / 1_000_000) * unitUs;
  endfunction

  // States in which the LED carries the carrier
  function automatic logic isMark(input beaconState_t s);
    return (s == HDR_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Square-wave carrier with a synchronous phase reset and a count enable.
// After a phase reset the output is high for CAR_DIV enabled cycles, then it
// toggles every CAR_DIV enabled cycles.
module ir_carrier_gen #(
  parameter int CAR_DIV = 1315
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic phaseRst,
  input  logic enable,
  output logic carrier
);

  localparam int PW = (CAR_DIV > 1) ? $clog2(CAR_DIV) : 1;

  logic [PW-1:0] phaseCnt;
  logic          toggled;

  // Half-period counter; flips the carrier flop each time it wraps
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      phaseCnt <= '0;
      toggled  <= 1'b0;
    end else if (phaseRst) begin
      phaseCnt <= '0;
      toggled  <= 1'b0;
    end else if (enable) begin
      if (phaseCnt == PW'(CAR_DIV - 1)) begin
        phaseCnt <= '0;
        toggled  <= ~toggled;
      end else begin
        phaseCnt <= phaseCnt + PW'(1);
      end
    end
  end

  // A cleared flop means the first half-period of a mark is high
  assign carrier = ~toggled;

endmodule

// File: rtl/ir_beacon_tx.sv
// Station-side IR beacon transmitter: pulse-distance frame carrying
// {stationID, payload} MSB first, carrier-modulated during marks, followed
// by an enforced LED-off guard gap.
// Build option: define BEACON_PARITY_EN to append an even-parity bit over
// ID+payload as the final data bit.
module ir_beacon_tx
  import ir_beacon_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int CARRIER_HZ  = 38_000,
  parameter int UNIT_US     = 600,
  parameter int ID_W        = 4,
  parameter int DATA_W      = 8,
  parameter int GUARD_UNITS = 8
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ID_W-1:0]   stationID,
  input  logic [DATA_W-1:0] payload,
  output logic              busy,
  output logic              done,
  output logic              irLED
);

  localparam int CAR_DIV  = calcCarDiv(CLK_HZ, CARRIER_HZ);
  localparam int UNIT_CYC = calcUnitCyc(CLK_HZ, UNIT_US);
`ifdef BEACON_PARITY_EN
  localparam int NBITS = ID_W + DATA_W + 1;
`else
  localparam int NBITS = ID_W + DATA_W;
`endif
  localparam int MAX_U = (GUARD_UNITS > HDR_MARK_U) ? GUARD_UNITS : HDR_MARK_U;
  localparam int UCW   = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
  localparam int ULW   = $clog2(MAX_U + 1);
  localparam int BCW   = (NBITS > 1) ? $clog2(NBITS) : 1;

  beaconState_t   state, stateNext;
  logic [UCW-1:0] unitCnt;
  logic [ULW-1:0] unitsLeft, loadUnits;
  logic [BCW-1:0] bitCnt;
  logic [NBITS-1:0] shiftReg, frameWord;
  logic unitDone, lastBit, curBit, markEntry, carrier;

`ifdef BEACON_PARITY_EN
  assign frameWord = {stationID, payload, ^{stationID, payload}};
`else
  assign frameWord = {stationID, payload};
`endif

  assign unitDone  = (unitCnt == '0) && (unitsLeft == '0);
  assign lastBit   = (bitCnt == BCW'(NBITS - 1));
  assign curBit    = shiftReg[NBITS-1];
  assign markEntry = isMark(stateNext) && !isMark(state);
  assign busy      = (state != IDLE);

  // State register
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Next state, and the unit count the next state will run for
  always_comb begin
    stateNext = state;
    loadUnits = '0;
    case (state)
      IDLE:      if (start)    stateNext = HDR_MARK;
      HDR_MARK:  if (unitDone) stateNext = HDR_SPACE;
      HDR_SPACE: if (unitDone) stateNext = BIT_MARK;
      BIT_MARK:  if (unitDone) stateNext = BIT_SPACE;
      BIT_SPACE: if (unitDone) stateNext = lastBit ? STOP_MARK : BIT_MARK;
      STOP_MARK: if (unitDone) stateNext = GUARD;
      GUARD:     if (unitDone) stateNext = IDLE;
      default:   stateNext = IDLE;
    endcase
    case (stateNext)
      HDR_MARK:  loadUnits = ULW'(HDR_MARK_U);
      HDR_SPACE: loadUnits = ULW'(HDR_SPACE_U);
      BIT_MARK:  loadUnits = ULW'(MARK_U);
      BIT_SPACE: loadUnits = curBit ? ULW'(ONE_SPACE_U) : ULW'(ZERO_SPACE_U);
      STOP_MARK: loadUnits = ULW'(MARK_U);
      GUARD:     loadUnits = ULW'(GUARD_UNITS);
      default:   loadUnits = '0;
    endcase
  end

  // Unit timing: reload on every state entry, count cycles within a unit and
  // units within the state
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      unitCnt   <= '0;
      unitsLeft <= '0;
    end else if (stateNext != state) begin
      if (stateNext == IDLE) begin
        unitCnt   <= '0;
        unitsLeft <= '0;
      end else begin
        unitCnt   <= UCW'(UNIT_CYC - 1);
        unitsLeft <= loadUnits - ULW'(1);
      end
    end else if (state != IDLE) begin
      if (unitCnt == '0) begin
        unitCnt   <= UCW'(UNIT_CYC - 1);
        unitsLeft <= unitsLeft - ULW'(1);
      end else begin
        unitCnt <= unitCnt - UCW'(1);
      end
    end
  end

  // Frame word capture on acceptance; advance one bit after each bit space
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      shiftReg <= '0;
      bitCnt   <= '0;
    end else if (state == IDLE && start) begin
      shiftReg <= frameWord;
      bitCnt   <= '0;
    end else if (state == BIT_SPACE && unitDone) begin
      shiftReg <= shiftReg << 1;
      bitCnt   <= bitCnt + BCW'(1);
    end
  end

  ir_carrier_gen #(
    .CAR_DIV(CAR_DIV)
  ) u_carrier (
    .CLK     (CLK),
    .rst_n   (rst_n),
    .phaseRst(markEntry),
    .enable  (isMark(state)),
    .carrier (carrier)
  );

  // Registered outputs: done marks the guard exit, LED gated by mark states
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      done  <= 1'b0;
      irLED <= 1'b0;
    end else begin
      done  <= (state == GUARD) && unitDone;
      irLED <= carrier & isMark(state);
    end
  end

endmodule

// File: tb/tb_ir_beacon_tx.sv
// Self-checking bench for ir_beacon_tx at reduced timing (CAR_DIV=5,
// UNIT_CYC=20). Expected LED waveforms are built from the frame's
// mark/space element list; follows BEACON_PARITY_EN when defined.
module tb_ir_beacon_tx;

  localparam int CD = 5;
  localparam int UC = 20;
  localparam int GU = 8;

  logic       CLK = 1'b0;
  logic       rst_n, start;
  logic [3:0] stationID;
  logic [7:0] payload;
  logic       busy, done, irLED;

  int checks = 0;
  int failures = 0;
  int cycleCnt = 0;
  int frameStart = 0;
  bit expLed[$];

  ir_beacon_tx #(
    .CLK_HZ(1_000_000), .CARRIER_HZ(100_000), .UNIT_US(20),
    .ID_W(4), .DATA_W(8), .GUARD_UNITS(GU)
  ) dut (
    .CLK(CLK), .rst_n(rst_n), .start(start), .stationID(stationID),
    .payload(payload), .busy(busy), .done(done), .irLED(irLED)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cycleCnt <= cycleCnt + 1;

  task automatic checkEq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic addSeg(input bit mark, input int units);
    for (int t = 0; t < units * UC; t++) expLed.push_back(mark && ((t / CD) % 2 == 0));
  endtask

  // Expected LED per frame cycle, and busy length from the unit-count formula
  task automatic buildModel(input logic [3:0] id, input logic [7:0] pl, output int formulaLen);
    bit bits[$];
    int ones;
    expLed.delete();
    for (int i = 3; i >= 0; i--) bits.push_back(id[i]);
    for (int i = 7; i >= 0; i--) bits.push_back(pl[i]);
`ifdef BEACON_PARITY_EN
    bits.push_back(^{id, pl});
`endif
    addSeg(1, 4);
    addSeg(0, 2);
    foreach (bits[i]) begin
      addSeg(1, 1);
      addSeg(0, bits[i] ? 2 : 1);
    end
    addSeg(1, 1);
    addSeg(0, GU);
    ones = 0;
    foreach (bits[i]) if (bits[i]) ones++;
    formulaLen = (6 + 2 * (bits.size() - ones) + 3 * ones + 1 + GU) * UC;
  endtask

  task automatic sendStart(input logic [3:0] id, input logic [7:0] pl, input bit hold);
    @(negedge CLK);
    stationID = id;
    payload   = pl;
    start     = 1'b1;
    @(posedge CLK);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Follow one frame from the cycle after acceptance to its done cycle
  task automatic observeFrame(input logic [3:0] id, input logic [7:0] pl, input string tag,
                              input int pulseAt, input int abortAt, input bit dropAtDone);
    int total, formulaLen;
    int ledErrs = 0, firstErr = -1, busyLen = 0, doneCnt = 0, doneAt = -1;
    bit expV, aborted;
    aborted = 1'b0;
    buildModel(id, pl, formulaLen);
    total = expLed.size();
    for (int c = 0; c <= total; c++) begin
      @(negedge CLK);
      if (c == 0) frameStart = cycleCnt;
      if (c == abortAt) begin
        rst_n = 1'b0;
        #1;
        checkEq({tag, ".rstLed"}, {31'd0, irLED}, 0);
        checkEq({tag, ".rstBusy"}, {31'd0, busy}, 0);
        checkEq({tag, ".rstDone"}, {31'd0, done}, 0);
        aborted = 1'b1;
        break;
      end
      expV = (c > 0) ? expLed[c-1] : 1'b0;
      if (irLED !== expV) begin
        ledErrs++;
        if (firstErr < 0) firstErr = c;
      end
      if (busy === 1'b1) busyLen++;
      if (done === 1'b1) begin
        doneCnt++;
        doneAt = c;
      end
      if (pulseAt >= 0 && c == pulseAt) begin
        start = 1'b1;
        stationID = 4'($urandom);
        payload = 8'($urandom);
      end else if (pulseAt >= 0 && c == pulseAt + 1) begin
        start = 1'b0;
      end
      if (c == total && dropAtDone) start = 1'b0;
    end
    checkEq($sformatf("%s.ledErrs(first@%0d)", tag, firstErr), ledErrs, 0);
    if (!aborted) begin
      checkEq({tag, ".busyLen"}, busyLen, formulaLen);
      checkEq({tag, ".doneCnt"}, doneCnt, 1);
      checkEq({tag, ".doneAt"}, doneAt, total);
    end
    $display("frame %s id=%h payload=%h cycles=%0d ledErrs=%0d busy=%0d", tag, id, pl, total, ledErrs, busyLen);
  endtask

  task automatic expectIdle(input string tag, input int n);
    int act = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (busy !== 1'b0 || done !== 1'b0 || irLED !== 1'b0) act++;
    end
    checkEq({tag, ".activeCycles"}, act, 0);
  endtask

  initial begin
    int prev;
    logic [3:0] rid;
    logic [7:0] rpl;
    rst_n = 1'b0;
    start = 1'b0;
    stationID = '0;
    payload = '0;
    repeat (3) @(negedge CLK);
    checkEq("reset.busy", {31'd0, busy}, 0);
    checkEq("reset.done", {31'd0, done}, 0);
    checkEq("reset.irLED", {31'd0, irLED}, 0);
    rst_n = 1'b1;
    expectIdle("idleAfterReset", 10);

    sendStart(4'hA, 8'h3C, 1'b0);
    observeFrame(4'hA, 8'h3C, "A3C", -1, -1, 1'b0);
    expectIdle("postA3C", 5);

    sendStart(4'hA, 8'h3C, 1'b0);
    observeFrame(4'hA, 8'h3C, "ignoreStart", 100, -1, 1'b0);
    expectIdle("noQueue", 50);

    sendStart(4'h0, 8'h00, 1'b1);
    observeFrame(4'h0, 8'h00, "hold1", -1, -1, 1'b0);
    prev = frameStart;
    observeFrame(4'h0, 8'h00, "hold2", -1, -1, 1'b0);
`ifdef BEACON_PARITY_EN
    checkEq("holdGap2", frameStart - prev, 821);
`else
    checkEq("holdGap2", frameStart - prev, 781);
`endif
    prev = frameStart;
    observeFrame(4'h0, 8'h00, "hold3", -1, -1, 1'b1);
`ifdef BEACON_PARITY_EN
    checkEq("holdGap3", frameStart - prev, 821);
`else
    checkEq("holdGap3", frameStart - prev, 781);
`endif
    expectIdle("afterHold", 20);

    rid = 4'($urandom);
    rpl = 8'($urandom);
    sendStart(rid, rpl, 1'b0);
    observeFrame(rid, rpl, "abort", -1, 300, 1'b0);
    repeat (2) @(negedge CLK);
    checkEq("inReset.busy", {31'd0, busy}, 0);
    rst_n = 1'b1;
    expectIdle("afterAbort", 10);
    sendStart(4'h5, 8'hA7, 1'b0);
    observeFrame(4'h5, 8'hA7, "postAbort", -1, -1, 1'b0);

    sendStart(4'hF, 8'hFF, 1'b0);
    observeFrame(4'hF, 8'hFF, "allOnes", -1, -1, 1'b0);

    for (int k = 0; k < 4; k++) begin
      rid = 4'($urandom);
      rpl = 8'($urandom);
      repeat ($urandom_range(0, 20)) @(negedge CLK);
      sendStart(rid, rpl, 1'b0);
      observeFrame(rid, rpl, $sformatf("rand%0d", k), -1, -1, 1'b0);
    end
    expectIdle("final", 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
